irq_encoder8to3: RTL

- Registered 8-to-3 interrupt-request encoder; the inverse direction of the 3-to-8 decoder used for one-hot select generation.
- Collects up to 8 request pulses into sticky pending bits.
- Priority-encodes the masked pending set into a 3-bit index.
- Presents the index to the control unit under a valid/ack handshake, then clears the serviced bit.
- Sits between peripheral request lines and the MIPS control/exception logic.

---
 rtl/irq_pkg.sv | 16 +
 rtl/prio_enc8to3.sv | 28 ++
 rtl/irq_encoder8to3.sv | 86 ++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared sizes, FSM state type and reset values for the 8-to-3 interrupt encoder.
package irq_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [NUM_REQ-1:0] RST_PENDING = '0;
  localparam logic [IDX_W-1:0]   RST_IDX     = '0;
  localparam logic [IDX_W-1:0]   RST_PTR     = 3'd7;

endpackage

// File: rtl/prio_enc8to3.sv
// Combinational priority encoder: finds the first set bit of vec searching
// upward from start and wrapping past 7 back to 0.
module prio_enc8to3
  import irq_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0] pos;

  // Walk from the farthest position back to start so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = start + IDX_W'(k);
      if (vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/irq_encoder8to3.sv
// Registered 8-to-3 interrupt encoder with sticky pending bits and valid/ack
// presentation. Define IRQ_ROUND_ROBIN_EN for rotating priority.
module irq_encoder8to3
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic               irq_ack,
  output logic               irq_valid,
  output logic [IDX_W-1:0]   irq_idx,
  output logic [NUM_REQ-1:0] pending,
  output logic               any_pending
);

  state_t             state;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] clr;
  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_found;
  logic               accept;

  assign eligible    = pending & mask;
  assign any_pending = |eligible;
  assign accept      = (state == PRESENT) && irq_ack;
  assign clr         = accept ? (NUM_REQ'(1) << irq_idx) : '0;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;

  // Last serviced index; the next search begins just past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= RST_PTR;
    end else if (accept) begin
      ptr <= irq_idx;
    end
  end

  assign start = ptr + IDX_W'(1);
`else
  assign start = '0;
`endif

  prio_enc8to3 u_prio (
    .vec   (eligible),
    .start (start),
    .idx   (enc_idx),
    .found (enc_found)
  );

  // A new request overrides a same-cycle clear so no pulse is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= RST_PENDING;
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_idx   <= RST_IDX;
    end else begin
      pending <= (pending & ~clr) | req;
      case (state)
        IDLE: begin
          if (en && enc_found) begin
            irq_idx   <= enc_idx;
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            irq_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
